// File: rtl/seq_shift_unit_if.sv
// Operand/result handshake bundle for seq_shift_unit.
// The producer/consumer side uses master; the shift unit uses slave.
interface seq_shift_unit_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: SLL, SRL, ROL and SRA, at most STEP bit positions
// per BUSY cycle. Operands and results move over valid/ready handshakes.
module seq_shift_unit #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_shift_unit_if.slave   bus
);

  localparam int LOG2N = $clog2(N);
  localparam int CW    = LOG2N + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [N-1:0]  N_VAL    = N'(N);
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;

  state_t        w_state_next;
  logic [N-1:0]  w_acc_next;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_op_next;

  logic [CW-1:0]         w_step;
  logic [CW-1:0]         w_cnt_rem;
  logic [CW-1:0]         w_load_cnt;
  logic [STEP:0][N-1:0]  w_cand;
  logic [N-1:0]          w_shifted;

  // Positions moved this cycle: the remaining count, capped at STEP.
  assign w_step    = (r_cnt < STEP_CNT) ? r_cnt : STEP_CNT;
  assign w_cnt_rem = r_cnt - w_step;

  // One candidate per legal step size; every shift amount is a constant,
  // so each candidate is pure wiring and only the final mux costs logic.
  genvar gi;
  generate
    for (gi = 0; gi <= STEP; gi++) begin : g_cand
      if (gi == 0) begin : g_zero
        assign w_cand[gi] = r_acc;
      end else if (gi == N) begin : g_full
        logic [N-1:0] w_val;
        // A full-width step empties the word (sign fill for SRA, identity for ROL).
        always_comb begin
          w_val = r_acc;
          case (r_op)
            OP_SLL:  w_val = '0;
            OP_SRL:  w_val = '0;
            OP_SRA:  w_val = {N{r_acc[N-1]}};
            default: w_val = r_acc;
          endcase
        end
        assign w_cand[gi] = w_val;
      end else begin : g_part
        logic [N-1:0] w_val;
        // Constant shift by gi positions for each operation.
        always_comb begin
          w_val = r_acc;
          case (r_op)
            OP_SLL:  w_val = {r_acc[N-1-gi:0], {gi{1'b0}}};
            OP_SRL:  w_val = {{gi{1'b0}}, r_acc[N-1:gi]};
            OP_SRA:  w_val = {{gi{r_acc[N-1]}}, r_acc[N-1:gi]};
            default: w_val = {r_acc[N-1-gi:0], r_acc[N-1:N-gi]};
          endcase
        end
        assign w_cand[gi] = w_val;
      end
    end
  endgenerate

  // Pick the candidate matching this cycle's step size.
  always_comb begin
    w_shifted = r_acc;
    for (int k = 0; k <= STEP; k++) begin
      if (w_step == CW'(k)) begin
        w_shifted = w_cand[k];
      end
    end
  end

  // Shift count loaded on accept: ROL wraps modulo N, the others clamp at N
  // (shifting N positions already produces the saturated result).
  always_comb begin
    w_load_cnt = bus.b[CW-1:0];
    if (bus.op == OP_ROL) begin
      w_load_cnt = {1'b0, bus.b[LOG2N-1:0]};
    end else if (bus.b >= N_VAL) begin
      w_load_cnt = N_CNT;
    end
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_acc_next   = bus.a;
          w_op_next    = bus.op;
          w_cnt_next   = w_load_cnt;
          w_state_next = (w_load_cnt == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_acc_next = w_shifted;
        w_cnt_next = w_cnt_rem;
        if (w_cnt_rem == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; a low rst_n at any edge abandons the current operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= OP_SLL;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
    end
  end

  // Outputs come from registered state; rst_n masks them as soon as it falls
  // so nothing is offered or accepted while reset is held.
  assign bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign bus.out_valid = rst_n && (r_state == S_DONE);
  assign bus.result    = (rst_n && (r_state == S_DONE)) ? r_acc : '0;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (N=32, STEP=4) using a result queue.
module tb_seq_shift_unit;

  localparam int N    = 32;
  localparam int STEP = 4;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t q_exp[$];

  seq_shift_unit_if #(.N(N)) bus ();

  seq_shift_unit #(.N(N), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges from the accept edge (edge 0) to the edge that can take the result.
  function automatic int exp_lat(input logic [31:0] b, input logic [1:0] op);
    int k;
    if (op == 2'b10) k = int'(b % 32);
    else if (b >= 32) k = 32;
    else k = int'(b);
    return (k + STEP - 1) / STEP + 1;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [31:0] r;
    int amt;
    case (op)
      2'b00: r = (b >= 32) ? 32'h0 : (a << b);
      2'b01: r = (b >= 32) ? 32'h0 : (a >> b);
      2'b11: r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
      default: begin
        amt = int'(b % 32);
        r = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
      end
    endcase
    return r;
  endfunction

  // Present an operand set and hold it until the unit takes it; the
  // expected result is queued at that point. Returns at accept edge + 1.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] exp_res);
    int guard;
    exp_t e;
    guard = 0;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    e.res = exp_res;
    e.lat = exp_lat(b, op);
    q_exp.push_back(e);
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_tests++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat=-1 when it never came.
  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b result=%h required 0 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle: in_ready=%b result=%h required 1 0", bus.in_ready, bus.result);
    end
    $display("[TB] txn reset released");
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    exp_t e;
    bit seen;
    send(32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midbusy_rst_low: in_ready=%b out_valid=%b required 0 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL midbusy_rst_edge: in_ready=%b out_valid=%b result=%h required 0 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midbusy_idle: in_ready=%b required 1", bus.in_ready);
    end
    q_exp.delete();
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midbusy_no_result: out_valid seen=1 required 0");
    end
    $display("[TB] txn SLL aborted by reset");
    send(32'h0000_00F0, 32'd4, 2'b01, 32'h0000_000F);
    wait_out(lat);
    e = q_exp.pop_front();
    n_tests++;
    if (bus.result !== e.res || lat !== e.lat) begin
      n_fail++;
      $display("FAIL after_reset_srl: result=%h lat=%0d required %h %0d", bus.result, lat, e.res, e.lat);
    end
    $display("[TB] txn SRL a=000000f0 b=4 result=%h lat=%0d", bus.result, lat);
    take_result();
  endtask

  // Runs a table of operations one at a time and checks result and latency.
  task automatic test_table(input string name, input logic [31:0] ta[3],
                            input logic [31:0] tb_[3], input logic [1:0] top[3],
                            input logic [31:0] tr[3], input int cnt);
    int lat;
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      send(ta[i], tb_[i], top[i], tr[i]);
      wait_out(lat);
      e = q_exp.pop_front();
      n_tests++;
      if (bus.result !== e.res) begin
        n_fail++;
        $display("FAIL %s_result[%0d]: got %h required %h", name, i, bus.result, e.res);
      end
      n_tests++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: got %0d required %0d", name, i, lat, e.lat);
      end
      $display("[TB] txn %s op=%0d a=%h b=%0d result=%h lat=%0d", name, top[i], ta[i], tb_[i], bus.result, lat);
      take_result();
    end
  endtask

  task automatic test_sra();
    logic [31:0] ta[3]  = '{32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF};
    logic [31:0] tb_[3] = '{32'd4, 32'd100, 32'd31};
    logic [1:0]  top[3] = '{2'b11, 2'b11, 2'b11};
    logic [31:0] tr[3]  = '{32'hF800_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    test_table("sra", ta, tb_, top, tr, 3);
  endtask

  task automatic test_sll_srl();
    logic [31:0] ta[3]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] tb_[3] = '{32'd31, 32'd40, 32'd0};
    logic [1:0]  top[3] = '{2'b00, 2'b01, 2'b00};
    logic [31:0] tr[3]  = '{32'h8000_0000, 32'h0000_0000, 32'h1234_5678};
    test_table("sllsrl", ta, tb_, top, tr, 3);
  endtask

  task automatic test_rol();
    logic [31:0] ta[3]  = '{32'h8000_0001, 32'h1234_5678, 32'h0};
    logic [31:0] tb_[3] = '{32'd33, 32'd8, 32'd0};
    logic [1:0]  top[3] = '{2'b10, 2'b10, 2'b10};
    logic [31:0] tr[3]  = '{32'h0000_0003, 32'h3456_7812, 32'h0};
    test_table("rol", ta, tb_, top, tr, 2);
  endtask

  task automatic test_random();
    logic [31:0] ta[3];
    logic [31:0] tb_[3];
    logic [1:0]  top[3];
    logic [31:0] tr[3];
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 3; i++) begin
        ta[i]  = $urandom;
        tb_[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
        top[i] = 2'($urandom_range(0, 3));
        tr[i]  = model(ta[i], tb_[i], top[i]);
      end
      test_table("rand", ta, tb_, top, tr, 3);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    bus.out_ready = 1'b0;
    send(32'h0000_FF00, 32'd8, 2'b01, 32'h0000_00FF);
    wait_out(lat);
    e = q_exp.pop_front();
    n_tests++;
    if (bus.result !== e.res || lat !== e.lat) begin
      n_fail++;
      $display("FAIL bp_first: result=%h lat=%0d required %h %0d", bus.result, lat, e.res, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.a = $urandom;
      bus.b = $urandom;
      bus.op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e.res) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h required 1 0 %h",
                 c, bus.out_valid, bus.in_ready, bus.result, e.res);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    $display("[TB] txn backpressure SRL result=%h held 5 cycles", e.res);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[3]  = '{32'h0000_0001, 32'hF000_0000, 32'h0000_0001};
    logic [31:0] tb_[3] = '{32'd2, 32'd8, 32'd31};
    logic [1:0]  top[3] = '{2'b00, 2'b11, 2'b10};
    logic [31:0] tr[3]  = '{32'h0000_0004, 32'hFFF0_0000, 32'h8000_0000};
    int lat;
    exp_t e;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = ta[0]; bus.b = tb_[0]; bus.op = top[0];
    e.res = tr[0]; e.lat = exp_lat(tb_[0], top[0]);
    q_exp.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_accept[%0d]: in_ready=%b required 0", i, bus.in_ready);
      end
      if (i < 2) begin
        bus.a = ta[i+1]; bus.b = tb_[i+1]; bus.op = top[i+1];
        e.res = tr[i+1]; e.lat = exp_lat(tb_[i+1], top[i+1]);
        q_exp.push_back(e);
      end
      wait_out(lat);
      e = q_exp.pop_front();
      n_tests++;
      if (bus.result !== e.res || lat !== e.lat) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: result=%h lat=%0d required %h %0d", i, bus.result, lat, e.res, e.lat);
      end
      $display("[TB] txn b2b op=%0d result=%h lat=%0d", top[i], bus.result, lat);
      @(posedge clk); #1;
      if (i == 2) bus.in_valid = 1'b0;
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle[%0d]: in_ready=%b out_valid=%b required 1 0", i, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = 2'b00;
    bus.out_ready = 1'b0;
    test_reset();
    test_reset_mid_busy();
    test_sra();
    test_sll_srl();
    test_rol();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
